// File: rtl/cpu_memory.sv
// ---------------------------------------------------------------------------
// cpu_memory
// Unified instruction/data memory for the single-cycle cpu core.
//   - Serves instr and readData combinationally; commits core stores on the
//     rising clock edge while the core runs.
//   - A load port fills the array with a program image while the core is
//     held in reset (cpuResetN low), then releases the core.
//   - Optional memory-mapped output register, enabled by defining the
//     macro CPU_MEMORY_IO_EN.
//
// Parameters:
//   WORDS   : array depth in 32-bit words (power of two, >= 4)
//   IO_ADDR : byte address of the output register (outside the array)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   instrAddr  in   fetch byte address          instr     out  fetched word
//   dataAddr   in   load/store byte address     readData  out  load data
//   writeData  in   store data                  we        in   store enable
//   loadValid  in   image word offered          loadData  in   image word
//   loadDone   in   image complete (sampled only while loading)
//   loadReady  out  array accepts image words
//   cpuResetN  out  active-low reset to the core
//   ioOut      out  output register             ioValid   out  write pulse
// ---------------------------------------------------------------------------
module cpu_memory #(
    parameter int          WORDS   = 256,
    parameter logic [31:0] IO_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrAddr,
    output logic [31:0] instr,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    input  logic        loadValid,
    input  logic [31:0] loadData,
    input  logic        loadDone,
    output logic        loadReady,
    output logic        cpuResetN,
    output logic [31:0] ioOut,
    output logic        ioValid
);
    localparam int              AW        = $clog2(WORDS);
    localparam logic [32:0]     MEM_BYTES = 33'(WORDS) * 33'd4;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] loadPtr;
    logic [31:0]   mem [WORDS];

    logic instrInRange;
    logic dataInRange;
    logic loadFire;
    logic storeFire;
    logic [31:0] arrayReadData;

    // Byte-lane bits are never used for word selection.
    logic unusedBits;
    assign unusedBits = ^{instrAddr[1:0], dataAddr[1:0]};

    assign instrInRange = ({1'b0, instrAddr} < MEM_BYTES);
    assign dataInRange  = ({1'b0, dataAddr} < MEM_BYTES);

    // loadReady is a registered copy of (state == LOAD), so it doubles as
    // the handshake qualifier.
    assign loadFire  = loadValid && loadReady;
    assign storeFire = we && (state == RUN) && dataInRange;

    // Control FSM with registered decoded outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            loadPtr   <= '0;
            loadReady <= 1'b0;
            cpuResetN <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= LOAD;
                    loadReady <= 1'b1;
                end
                LOAD: begin
                    if (loadFire) begin
                        loadPtr <= loadPtr + 1'b1;
                    end
                    // Same-edge word + done: the word is written by the
                    // array block on this edge, and we leave LOAD.
                    if (loadDone || (loadFire && loadPtr == LAST_IDX)) begin
                        state     <= HOLD;
                        loadReady <= 1'b0;
                    end
                end
                HOLD: begin
                    // Guarantees the core sees at least one edge in reset.
                    state     <= RUN;
                    cpuResetN <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Array contents survive reset, so the write port carries no reset.
    // Load and store writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            mem[loadPtr] <= loadData;
        end else if (storeFire) begin
            mem[dataAddr[AW+1:2]] <= writeData;
        end
    end

    assign instr         = instrInRange ? mem[instrAddr[AW+1:2]] : 32'h0;
    assign arrayReadData = dataInRange  ? mem[dataAddr[AW+1:2]]  : 32'h0;

`ifdef CPU_MEMORY_IO_EN
    logic ioHit;
    logic ioStore;

    assign ioHit   = (dataAddr == IO_ADDR);
    assign ioStore = we && (state == RUN) && ioHit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ioOut   <= 32'h0;
            ioValid <= 1'b0;
        end else begin
            ioValid <= ioStore;
            if (ioStore) begin
                ioOut <= writeData;
            end
        end
    end

    assign readData = ioHit ? ioOut : arrayReadData;
`else
    // IO_ADDR behaves as an ordinary out-of-range address.
    assign ioOut    = 32'h0;
    assign ioValid  = 1'b0;
    assign readData = arrayReadData;
`endif

endmodule

// File: tb/tb_cpu_memory.sv
// ---------------------------------------------------------------------------
// tb_cpu_memory
// Self-checking bench for cpu_memory. Instance dut uses WORDS=256 for the
// load/run/IO/reset sequences and randomized traffic; instance dutSmall uses
// WORDS=4 for the load-full auto-termination case.
// ---------------------------------------------------------------------------
module tb_cpu_memory;
    localparam logic [31:0] IO_ADDR = 32'h0000_1000;
`ifdef CPU_MEMORY_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        reset, we, loadValid, loadDone, loadReady, cpuResetN, ioValid;
    logic [31:0] instrAddr, instr, dataAddr, writeData, readData, loadData, ioOut;
    // Small instance
    logic        sReset, sWe, sLoadValid, sLoadDone, sLoadReady, sCpuResetN, sIoValid;
    logic [31:0] sInstrAddr, sInstr, sDataAddr, sWriteData, sReadData, sLoadData, sIoOut;

    cpu_memory #(.WORDS(256), .IO_ADDR(IO_ADDR)) dut (
        .clk(clk), .reset(reset), .instrAddr(instrAddr), .instr(instr),
        .dataAddr(dataAddr), .writeData(writeData), .we(we), .readData(readData),
        .loadValid(loadValid), .loadData(loadData), .loadDone(loadDone),
        .loadReady(loadReady), .cpuResetN(cpuResetN), .ioOut(ioOut), .ioValid(ioValid)
    );

    cpu_memory #(.WORDS(4), .IO_ADDR(IO_ADDR)) dutSmall (
        .clk(clk), .reset(sReset), .instrAddr(sInstrAddr), .instr(sInstr),
        .dataAddr(sDataAddr), .writeData(sWriteData), .we(sWe), .readData(sReadData),
        .loadValid(sLoadValid), .loadData(sLoadData), .loadDone(sLoadDone),
        .loadReady(sLoadReady), .cpuResetN(sCpuResetN), .ioOut(sIoOut), .ioValid(sIoValid)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural reference: word-indexed array plus known flags.
    logic [31:0] refMem [256];
    bit          refKnown [256];
    logic [31:0] refIo;

    function automatic bit isArray(input logic [31:0] a);
        return a < 32'd1024;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        if (IO_EN && a == IO_ADDR) return refIo;
        if (isArray(a)) return refMem[a / 4];
        return 32'h0;
    endfunction

    function automatic bit refIsKnown(input logic [31:0] a);
        if (isArray(a)) return refKnown[a / 4];
        return 1'b1;
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [31:0] d);
        if (isArray(a)) begin
            refMem[a / 4]   = d;
            refKnown[a / 4] = 1'b1;
        end else if (IO_EN && a == IO_ADDR) begin
            refIo = d;
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } rdVec_t;

    rdVec_t vecs [7];

    localparam logic [31:0] W0 = 32'h0000_2083;
    localparam logic [31:0] W1 = 32'h0010_80B3;
    localparam logic [31:0] W2 = 32'h0010_2023;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, ia, wd;
        bit          w, expValid;

        vecs[0] = '{"rd word0",       32'h0000_0000, W0};
        vecs[1] = '{"rd word1",       32'h0000_0004, W1};
        vecs[2] = '{"rd word2",       32'h0000_0008, W2};
        vecs[3] = '{"rd word1 lsb",   32'h0000_0005, W1};
        vecs[4] = '{"rd oob 0x400",   32'h0000_0400, 32'h0};
        vecs[5] = '{"rd oob high",    32'hFFFF_FFFC, 32'h0};
        vecs[6] = '{"rd word2 lsb3",  32'h0000_000B, W2};

        for (int i = 0; i < 256; i++) refKnown[i] = 1'b0;
        refIo = 32'h0;

        reset = 1'b1; we = 1'b0; loadValid = 1'b0; loadDone = 1'b0;
        instrAddr = '0; dataAddr = '0; writeData = '0; loadData = '0;
        sReset = 1'b1; sWe = 1'b0; sLoadValid = 1'b0; sLoadDone = 1'b0;
        sInstrAddr = '0; sDataAddr = '0; sWriteData = '0; sLoadData = '0;

        repeat (2) @(negedge clk);
        check("reset loadReady", {31'b0, loadReady}, 32'd0);
        check("reset cpuResetN", {31'b0, cpuResetN}, 32'd0);
        check("reset ioOut", ioOut, 32'h0);
        check("reset ioValid", {31'b0, ioValid}, 32'd0);

        // Release reset: first edge enters LOAD.
        reset = 1'b0;
        tick();
        check("load loadReady", {31'b0, loadReady}, 32'd1);
        check("load cpuResetN", {31'b0, cpuResetN}, 32'd0);

        // Word 0, then a core store during LOAD with no handshake.
        loadValid = 1'b1; loadData = W0;
        tick();
        refStore(32'h0, W0);
        loadValid = 1'b0; we = 1'b1; dataAddr = 32'h0; writeData = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;
        check("no-done loadReady", {31'b0, loadReady}, 32'd1);

        loadValid = 1'b1; loadData = W1;
        tick();
        refStore(32'h4, W1);
        loadData = W2; loadDone = 1'b1;
        tick();
        refStore(32'h8, W2);
        loadValid = 1'b0; loadDone = 1'b0;
        check("done loadReady", {31'b0, loadReady}, 32'd0);
        check("done cpuResetN", {31'b0, cpuResetN}, 32'd0);
        tick();
        check("run cpuResetN", {31'b0, cpuResetN}, 32'd1);
        check("run loadReady", {31'b0, loadReady}, 32'd0);

        // Table-driven reads on both ports.
        for (int i = 0; i < 7; i++) begin
            instrAddr = vecs[i].addr;
            dataAddr  = vecs[i].addr;
            #1;
            check({vecs[i].name, " instr"}, instr, vecs[i].exp);
            check({vecs[i].name, " data"}, readData, vecs[i].exp);
        end

        // Store then load in RUN.
        we = 1'b1; dataAddr = 32'h10; writeData = 32'h0000_01FE;
        tick();
        we = 1'b0;
        refStore(32'h10, 32'h0000_01FE);
        #1 check("store rd 0x10", readData, 32'h0000_01FE);
        dataAddr = 32'h13;
        #1 check("store rd 0x13", readData, 32'h0000_01FE);
        instrAddr = 32'h10;
        #1 check("store instr 0x10", instr, 32'h0000_01FE);

        // Read-during-write returns the old word until the edge.
        we = 1'b1; dataAddr = 32'h8; writeData = 32'h55AA_33CC;
        #1 check("rdw old", readData, W2);
        tick();
        we = 1'b0;
        refStore(32'h8, 32'h55AA_33CC);
        #1 check("rdw new", readData, 32'h55AA_33CC);

        // Out-of-range store is dropped (must not alias onto word 0).
        we = 1'b1; dataAddr = 32'h400; writeData = 32'h1111_1111;
        tick();
        we = 1'b0;
        #1 check("oob store rd", readData, 32'h0);
        dataAddr = 32'h0;
        #1 check("oob store word0", readData, W0);

        // Output register: back-to-back stores, then idle.
        we = 1'b1; dataAddr = IO_ADDR; writeData = 32'h0000_00FF;
        tick();
        refStore(IO_ADDR, 32'h0000_00FF);
        check("io ioOut", ioOut, refIo);
        check("io ioValid 1st", {31'b0, ioValid}, {31'b0, IO_EN});
        writeData = 32'h0000_0ABC;
        tick();
        refStore(IO_ADDR, 32'h0000_0ABC);
        we = 1'b0;
        check("io ioValid 2nd", {31'b0, ioValid}, {31'b0, IO_EN});
        tick();
        check("io ioValid idle", {31'b0, ioValid}, 32'd0);
        check("io ioOut hold", ioOut, refIo);
        #1 check("io load", readData, refRead(IO_ADDR));
        dataAddr = 32'h0;
        #1 check("io word0 intact", readData, W0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = {$urandom_range(0, 31) * 4} | 32'($urandom_range(0, 3));
                7:       a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
                8:       a = IO_ADDR;
                default: a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            endcase
            ia = 32'($urandom_range(0, 127));
            wd = $urandom;
            w  = ($urandom_range(0, 1) == 1);
            dataAddr = a; instrAddr = ia; writeData = wd; we = w;
            #1;
            if (refIsKnown(a)) check("rand data", readData, refRead(a));
            if (refIsKnown(ia)) check("rand instr", instr, refRead(ia));
            tick();
            expValid = w && IO_EN && (a == IO_ADDR);
            if (w) refStore(a, wd);
            check("rand ioValid", {31'b0, ioValid}, {31'b0, expValid});
            check("rand ioOut", ioOut, refIo);
        end
        we = 1'b0;

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        refIo = 32'h0;
        check("mid reset cpuResetN", {31'b0, cpuResetN}, 32'd0);
        check("mid reset loadReady", {31'b0, loadReady}, 32'd0);
        check("mid reset ioOut", ioOut, 32'h0);
        check("mid reset ioValid", {31'b0, ioValid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("reload loadReady", {31'b0, loadReady}, 32'd1);
        loadValid = 1'b1; loadData = 32'hCAFE_F00D; loadDone = 1'b1;
        tick();
        refStore(32'h0, 32'hCAFE_F00D);
        loadValid = 1'b0; loadDone = 1'b0;
        check("reload done loadReady", {31'b0, loadReady}, 32'd0);
        tick();
        check("reload cpuResetN", {31'b0, cpuResetN}, 32'd1);
        dataAddr = 32'h0;
        #1 check("reload ptr0 word", readData, 32'hCAFE_F00D);
        dataAddr = 32'h4;
        #1 check("retained word1", readData, refRead(32'h4));
        instrAddr = 32'h10;
        #1 check("retained word4", instr, refRead(32'h10));

        // WORDS=4: five words offered without loadDone.
        sReset = 1'b0;
        tick();
        check("small loadReady", {31'b0, sLoadReady}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            sLoadValid = 1'b1;
            sLoadData  = 32'hA0 + 32'(k);
            tick();
            check($sformatf("small w%0d loadReady", k), {31'b0, sLoadReady}, (k < 3) ? 32'd1 : 32'd0);
            check($sformatf("small w%0d cpuResetN", k), {31'b0, sCpuResetN}, (k == 4) ? 32'd1 : 32'd0);
        end
        sLoadValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sInstrAddr = 32'(k) * 4;
            #1 check($sformatf("small word%0d", k), sInstr, 32'hA0 + 32'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_memory.md
# cpu_memory

Unified instruction/data memory that answers the single-cycle `cpu` core's fetch and load/store interface. It serves `instr` and `readData` combinationally and commits stores on the clock edge. A load port fills the array with a program image while the core is held in reset, then releases the core. Optionally it decodes one memory-mapped output register. It sits beside `cpu` at top level, with `cpuResetN` wired to the core's `n_reset`.

## Interface
- `WORDS`, 256: array depth in 32-bit words; power of two, ≥ 4; `AW = $clog2(WORDS)`.
- `IO_ADDR`, 32'h0000_1000: byte address of the output register; must lie outside `0 .. WORDS*4-1`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instrAddr` in 32: core fetch byte address.
- `instr` out 32: fetched word.
- `dataAddr` in 32: core load/store byte address.
- `writeData` in 32: store data.
- `we` in 1: store enable.
- `readData` out 32: load data.
- `loadValid` in 1: image word offered.
- `loadData` in 32: image word.
- `loadDone` in 1: image complete; sampled only in LOAD.
- `loadReady` out 1: array accepts image words.
- `cpuResetN` out 1: active-low reset to the core.
- `ioOut` out 32: output register.
- `ioValid` out 1: one-cycle pulse after each output-register write.

## Operation
- State machine states: IDLE (reset state), LOAD, HOLD, RUN.
  - IDLE → LOAD unconditionally.
  - LOAD → HOLD on `loadDone`, or when the word at index `WORDS-1` is accepted.
  - HOLD → RUN unconditionally.
  - RUN stays in RUN until `reset`.
- Decoded outputs:
  - `loadReady = (state == LOAD)`.
  - `cpuResetN = (state == RUN)`.
- Load:
  - Handshake is `loadValid && loadReady`.
  - On a handshake, write `loadData` to `mem[loadPtr]` and increment `loadPtr`. `loadPtr` is AW bits and resets to 0.
  - If `loadValid` and `loadDone` are high on the same edge, the word is written first, then the state moves to HOLD.
- Reads are combinational and active in every state:
  - `instr = mem[instrAddr[AW+1:2]]` when `instrAddr < WORDS*4`, else 0.
  - `readData` uses the same rule with `dataAddr`. With IO enabled, `dataAddr == IO_ADDR` returns `ioOut`.
  - Address bits [1:0] are ignored.
- Core stores: `mem[dataAddr[AW+1:2]] <= writeData` on the edge when `we && state == RUN && dataAddr < WORDS*4`.
  - Out-of-range stores are dropped.
  - `we` outside RUN is ignored.
- Array contents are not cleared by `reset`.

## Timing
- Values while `reset` is asserted: state IDLE, `loadPtr` 0, `loadReady` 0, `cpuResetN` 0, `ioOut` 0, `ioValid` 0.
- First edge after `reset` deasserts: LOAD, so `loadReady` = 1.
- `loadDone` sampled at edge N: `loadReady` = 0 after edge N; `cpuResetN` = 1 after edge N+1. The core therefore sees at least one rising edge with `n_reset` = 0 and starts fetching at PC 0.
- Read latency: 0 cycles (combinational from address).
- Store-to-load latency: data is visible on `readData`/`instr` immediately after the storing edge.
- Read-during-write to the same address returns the old word until the edge.
- `reset` mid-operation, any state:
  - Outputs take their reset values asynchronously; the core is re-held in reset.
  - A fresh load is required; array contents are retained.

## Configuration
- `CPU_MEMORY_IO_EN` defined:
  - RUN-state store to `IO_ADDR` loads `ioOut <= writeData` and sets `ioValid` = 1 for the following cycle only. Back-to-back stores give back-to-back pulses.
  - The array is not written.
  - Loads from `IO_ADDR` return `ioOut`.
- Not defined:
  - `IO_ADDR` decodes as an ordinary out-of-range address: stores are dropped and loads return 0.
  - `ioOut` and `ioValid` are tied to 0.

## Test plan
- Load and release: reset, then accept 3 words 0x00002083, 0x001080B3, 0x00102023, with `loadDone` on the 3rd.
  - Required: `loadReady` drops after that edge; `cpuResetN` = 1 one edge later.
  - Required: `instrAddr` = 4 → `instr` = 0x001080B3; `instrAddr` = 0x400 → 0.
- Store/load in RUN: `we` = 1, `dataAddr` = 0x10, `writeData` = 0x000001FE for one edge.
  - Required: `dataAddr` = 0x10 reads 0x000001FE; `dataAddr` = 0x13 reads the same value.
- Store ignored outside RUN: `we` = 1, `dataAddr` = 0, `writeData` = 0xDEADBEEF during LOAD with no handshake.
  - Required: after release, `readData` at 0 still equals the loaded word.
- Auto-terminate on full (`WORDS` = 4): offer 5 words without `loadDone`.
  - Required: 4 accepted; `loadReady` = 0 after the 4th; the 5th word is never written; RUN follows.
- IO (`CPU_MEMORY_IO_EN`): RUN store 0x000000FF to `IO_ADDR`.
  - Required: `ioOut` = 0xFF and a single-cycle `ioValid` pulse.
  - Required: load from `IO_ADDR` returns 0xFF; no array word changes.
  - Without the macro: `ioOut` stays 0 and the load returns 0.
- Reset mid-RUN: assert `reset` between edges.
  - Required: `cpuResetN` = 0 and `loadReady` = 0 immediately.
  - Required: after release, LOAD state with `loadPtr` 0, and previously loaded words still readable.
